// File: rtl/io_pkg.sv
// Shared types and helpers for the typewriter output stage.
// Contents: OF class codes, FIFO entry layout, FSM state enum and the
// OF/OB -> ASCII translation used by io_typeout.
package io_pkg;

  // {OF3,OF2,OF1} class codes; 3'b110 is unused and emits nothing
  localparam logic [2:0] CLS_DIGIT  = 3'b000;
  localparam logic [2:0] CLS_SIGN   = 3'b001;
  localparam logic [2:0] CLS_TAB    = 3'b010;
  localparam logic [2:0] CLS_CR     = 3'b011;
  localparam logic [2:0] CLS_STOP   = 3'b100;
  localparam logic [2:0] CLS_RELOAD = 3'b101;
  localparam logic [2:0] CLS_WAIT   = 3'b111;

  localparam int unsigned CHAR_W = 7;

  // One queued character as captured from the OF/OB flip-flops
  typedef struct packed {
    logic [2:0] cls;
    logic [3:0] code;
  } char_t;

  // Translation result: has_byte=0 means the class produces no output
  typedef struct packed {
    logic       has_byte;
    logic [7:0] data;
  } ascii_t;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    SEND,
    SEND_LF,
    PACE,
    DONE
  } typeout_state_t;

  // First byte of a character; CR's trailing LF is produced by the FSM
  function automatic ascii_t g15_char_to_ascii(input logic [2:0] cls,
                                               input logic [3:0] code);
    ascii_t r;
    r.has_byte = 1'b0;
    r.data     = 8'h00;
    case (cls)
      CLS_DIGIT: begin
        r.has_byte = 1'b1;
        // 0-9 -> '0'-'9'; 10-15 -> 'u'-'z' (0x6B + 10 = 'u')
        r.data = (code < 4'd10) ? (8'h30 + {4'h0, code})
                                : (8'h6B + {4'h0, code});
      end
      CLS_SIGN: begin
        r.has_byte = code[0];
        r.data     = 8'h2D;
      end
      CLS_TAB: begin
        r.has_byte = 1'b1;
        r.data     = 8'h09;
      end
      CLS_CR: begin
        r.has_byte = 1'b1;
        r.data     = 8'h0D;
      end
      CLS_STOP, CLS_RELOAD, CLS_WAIT: r.has_byte = 1'b0;
      default: r.has_byte = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/io_typeout_if.sv
// Character input and host byte-sink signals of io_typeout.
// master: upstream OF/OB stage plus host sink (drives strobe/char, TX_READY)
// slave : io_typeout (drives TX_DATA/TX_VALID)
interface io_typeout_if;
  logic       CHAR_STB;
  logic [2:0] CHAR_OF;
  logic [3:0] CHAR_OB;
  logic [7:0] TX_DATA;
  logic       TX_VALID;
  logic       TX_READY;

  modport master (output CHAR_STB, CHAR_OF, CHAR_OB, TX_READY,
                  input  TX_DATA, TX_VALID);
  modport slave  (input  CHAR_STB, CHAR_OF, CHAR_OB, TX_READY,
                  output TX_DATA, TX_VALID);
endinterface

// File: rtl/char_fifo.sv
// Small synchronous FIFO for queued characters.
// Ports: clk, rst (async high), push/wdata, pop/rdata (show-ahead),
//        full, empty, count (occupancy, 0..DEPTH).
// A push while full is accepted only if a pop frees the slot in the same cycle.
module char_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 7,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: occupancy gates every read
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/io_typeout.sv
// Typewriter output stage: queues OF/OB characters, translates them to
// ASCII, hands bytes to the host sink and paces at typewriter speed.
// Ports: CLOCK, rst (async high), bus (char strobe in, TX valid/ready out),
//        CLR_OVR, FB (per-character feedback pulse), STOP_SEEN, BUSY,
//        FULL, OVERRUN (sticky drop flag).
module io_typeout
  import io_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CHAR_TICKS = 100
) (
  input  logic         CLOCK,
  input  logic         rst,
  io_typeout_if.slave  bus,
  input  logic         CLR_OVR,
  output logic         FB,
  output logic         STOP_SEEN,
  output logic         BUSY,
  output logic         FULL,
  output logic         OVERRUN
);

  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned PACE_W = (CHAR_TICKS > 1) ? $clog2(CHAR_TICKS) : 1;

  typeout_state_t    state_q, state_d;
  char_t             fifo_wdata, fifo_rdata, hold_q;
  ascii_t            dec;
  logic              fifo_full, fifo_empty, pop_c, handshake;
  logic [CNT_W-1:0]  fifo_count;
  logic [PACE_W-1:0] pace_q, pace_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d, fb_d, stop_d;

  assign fifo_wdata = '{cls: bus.CHAR_OF, code: bus.CHAR_OB};
  assign dec        = g15_char_to_ascii(hold_q.cls, hold_q.code);
  assign handshake  = tx_valid_q & bus.TX_READY;

  char_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(CHAR_W)) u_fifo (
    .clk   (CLOCK),
    .rst   (rst),
    .push  (bus.CHAR_STB),
    .wdata (fifo_wdata),
    .pop   (pop_c),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // State register
  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; pop is issued from IDLE only
  always_comb begin
    state_d = state_q;
    pop_c   = 1'b0;
    case (state_q)
      IDLE: if (!fifo_empty) begin
        pop_c   = 1'b1;
        state_d = DECODE;
      end
      DECODE:  state_d = dec.has_byte ? SEND : DONE;
      SEND:    if (handshake) state_d = (hold_q.cls == CLS_CR) ? SEND_LF : PACE;
      SEND_LF: if (handshake) state_d = PACE;
      PACE:    if (pace_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs, keyed on state_d
  always_comb begin
    tx_valid_d = (state_d == SEND) || (state_d == SEND_LF);
    tx_data_d  = tx_data_q;
    fb_d       = (state_d == DONE);
    stop_d     = (state_d == DONE) && (hold_q.cls == CLS_STOP);
    pace_d     = pace_q;
    if (state_q == DECODE && state_d == SEND)       tx_data_d = dec.data;
    else if (state_q == SEND && state_d == SEND_LF) tx_data_d = 8'h0A;
    if (state_q != PACE && state_d == PACE)         pace_d = PACE_W'(CHAR_TICKS - 1);
    else if (state_q == PACE && pace_q != '0)       pace_d = pace_q - PACE_W'(1);
  end

  // Registered outputs, holding register and sticky overrun (set beats clear)
  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      FB         <= 1'b0;
      STOP_SEEN  <= 1'b0;
      pace_q     <= '0;
      hold_q     <= '0;
      OVERRUN    <= 1'b0;
    end else begin
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      FB         <= fb_d;
      STOP_SEEN  <= stop_d;
      pace_q     <= pace_d;
      if (pop_c) hold_q <= fifo_rdata;
      if (bus.CHAR_STB && fifo_full && !pop_c) OVERRUN <= 1'b1;
      else if (CLR_OVR)                        OVERRUN <= 1'b0;
    end
  end

  assign bus.TX_DATA  = tx_data_q;
  assign bus.TX_VALID = tx_valid_q;
  assign FULL         = fifo_full;
  assign BUSY         = (fifo_count != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_io_typeout.sv
// Directed self-checking bench for io_typeout (FIFO_DEPTH=4, CHAR_TICKS=4).
// Cycle numbers: cyc counts rising edges; a strobe "at n" is sampled by edge n,
// and monitor timestamps are the cyc value in the cycle an output is high.
module tb_io_typeout;
  import io_pkg::*;

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned CHAR_TICKS = 4;

  logic CLOCK = 1'b0;
  logic rst   = 1'b0;
  logic CLR_OVR, FB, STOP_SEEN, BUSY, FULL, OVERRUN;

  io_typeout_if bus ();

  io_typeout #(.FIFO_DEPTH(FIFO_DEPTH), .CHAR_TICKS(CHAR_TICKS)) dut (
    .CLOCK     (CLOCK),
    .rst       (rst),
    .bus       (bus),
    .CLR_OVR   (CLR_OVR),
    .FB        (FB),
    .STOP_SEEN (STOP_SEEN),
    .BUSY      (BUSY),
    .FULL      (FULL),
    .OVERRUN   (OVERRUN)
  );

  always #5 CLOCK = ~CLOCK;

  int cyc = 0;
  always @(posedge CLOCK) cyc = cyc + 1;

  int checks   = 0;
  int failures = 0;

  logic [7:0] bytes_q [$];
  int         byte_cyc [$];
  int         fb_cyc [$];
  int         fb_cnt, stop_cnt, stop_cyc, valid_cnt;

  // Monitor on the falling edge, where inputs and outputs are stable
  always @(negedge CLOCK) begin
    if (bus.TX_VALID === 1'b1 && bus.TX_READY === 1'b1) begin
      bytes_q.push_back(bus.TX_DATA);
      byte_cyc.push_back(cyc);
    end
    if (bus.TX_VALID === 1'b1) valid_cnt++;
    if (FB === 1'b1) begin
      fb_cnt++;
      fb_cyc.push_back(cyc);
    end
    if (STOP_SEEN === 1'b1) begin
      stop_cnt++;
      stop_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic clear_mon();
    bytes_q.delete();
    byte_cyc.delete();
    fb_cyc.delete();
    fb_cnt    = 0;
    stop_cnt  = 0;
    stop_cyc  = -1;
    valid_cnt = 0;
  endtask

  task automatic strobe(input logic [2:0] c, input logic [3:0] o);
    bus.CHAR_STB = 1'b1;
    bus.CHAR_OF  = c;
    bus.CHAR_OB  = o;
    tick();
    bus.CHAR_STB = 1'b0;
  endtask

  task automatic wait_fb(input int n, input int budget, input string tag);
    int k = 0;
    while (fb_cnt < n && k < budget) begin
      tick();
      k++;
    end
    chk(tag, 32'(fb_cnt), 32'(n));
  endtask

  function automatic logic [7:0] qb(input int i);
    return (i < bytes_q.size()) ? bytes_q[i] : 8'hxx;
  endfunction

  function automatic int qf(input int i);
    return (i < fb_cyc.size()) ? fb_cyc[i] : -1000;
  endfunction

  function automatic int qc(input int i);
    return (i < byte_cyc.size()) ? byte_cyc[i] : -1000;
  endfunction

  initial begin
    int n;
    int r;
    logic [7:0] exp3 [6];
    logic [7:0] exp6 [4];
    exp3 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h37};
    exp6 = '{8'h2D, 8'h30, 8'h7A, 8'h09};

    bus.CHAR_STB = 1'b0;
    bus.CHAR_OF  = 3'd0;
    bus.CHAR_OB  = 4'd0;
    bus.TX_READY = 1'b0;
    CLR_OVR      = 1'b0;
    clear_mon();

    // Reset values, checked before any clock edge
    #1 rst = 1'b1;
    #2;
    chk("rst_tx_data",  32'(bus.TX_DATA), 32'h00);
    chk("rst_tx_valid", 32'(bus.TX_VALID), 32'd0);
    chk("rst_fb",       32'(FB), 32'd0);
    chk("rst_stop",     32'(STOP_SEEN), 32'd0);
    chk("rst_busy",     32'(BUSY), 32'd0);
    chk("rst_full",     32'(FULL), 32'd0);
    chk("rst_overrun",  32'(OVERRUN), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Two digits, sink always ready: '7' then code 12 -> 'w'
    bus.TX_READY = 1'b1;
    clear_mon();
    strobe(CLS_DIGIT, 4'd7);
    n = cyc;
    strobe(CLS_DIGIT, 4'd12);
    wait_fb(2, 200, "t1_fb_timeout");
    chk("t1_nbytes",  32'(bytes_q.size()), 32'd2);
    chk("t1_byte0",   32'(qb(0)), 32'h37);
    chk("t1_byte1",   32'(qb(1)), 32'h77);
    chk("t1_valid0",  32'(qc(0) - n), 32'd2);
    chk("t1_fb0",     32'(qf(0) - n), 32'(3 + CHAR_TICKS));
    chk("t1_valid1",  32'(qc(1) - n), 32'd10);
    chk("t1_fb1",     32'(qf(1) - n), 32'(11 + CHAR_TICKS));

    // CR with sink stalled: 0x0D must stay valid and stable
    repeat (3) tick();
    bus.TX_READY = 1'b0;
    clear_mon();
    strobe(CLS_CR, 4'd0);
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("t2_stall_valid", 32'(bus.TX_VALID), 32'd1);
      chk("t2_stall_data",  32'(bus.TX_DATA), 32'h0D);
      tick();
    end
    bus.TX_READY = 1'b1;
    wait_fb(1, 100, "t2_fb_timeout");
    repeat (20) tick();
    chk("t2_fb_count", 32'(fb_cnt), 32'd1);
    chk("t2_nbytes",   32'(bytes_q.size()), 32'd2);
    chk("t2_byte0",    32'(qb(0)), 32'h0D);
    chk("t2_byte1",    32'(qb(1)), 32'h0A);

    // Fill while stalled: first char sits in SEND, next four fill the FIFO
    bus.TX_READY = 1'b0;
    clear_mon();
    for (int i = 1; i <= 5; i++) strobe(CLS_DIGIT, 4'(i));
    chk("t3_full",        32'(FULL), 32'd1);
    chk("t3_ovr_pre",     32'(OVERRUN), 32'd0);
    strobe(CLS_DIGIT, 4'd6);
    chk("t3_ovr_set",     32'(OVERRUN), 32'd1);
    chk("t3_busy",        32'(BUSY), 32'd1);
    CLR_OVR = 1'b1;
    tick();
    CLR_OVR = 1'b0;
    chk("t3_ovr_clr",     32'(OVERRUN), 32'd0);
    // Release; the first pop lands 7 edges later, so time a push to that edge
    bus.TX_READY = 1'b1;
    r = cyc;
    repeat (6) tick();
    chk("t3_full_pre_pop", 32'(FULL), 32'd1);
    chk("t3_cyc_align",    32'(cyc - r), 32'd6);
    strobe(CLS_DIGIT, 4'd7);
    chk("t3_ovr_pushpop",  32'(OVERRUN), 32'd0);
    chk("t3_full_pushpop", 32'(FULL), 32'd1);
    wait_fb(6, 400, "t3_fb_timeout");
    chk("t3_nbytes", 32'(bytes_q.size()), 32'd6);
    for (int i = 0; i < 6; i++) chk("t3_byte", 32'(qb(i)), 32'(exp3[i]));

    // No-byte classes: STOP, SIGN(+), WAIT, RELOAD
    repeat (5) tick();
    clear_mon();
    strobe(CLS_STOP, 4'd0);
    n = cyc;
    strobe(CLS_SIGN, 4'd0);
    strobe(CLS_WAIT, 4'd3);
    strobe(CLS_RELOAD, 4'd5);
    wait_fb(4, 100, "t4_fb_timeout");
    repeat (10) tick();
    chk("t4_valid_cnt", 32'(valid_cnt), 32'd0);
    chk("t4_nbytes",    32'(bytes_q.size()), 32'd0);
    chk("t4_fb_count",  32'(fb_cnt), 32'd4);
    chk("t4_stop_cnt",  32'(stop_cnt), 32'd1);
    chk("t4_stop_cyc",  32'(stop_cyc - n), 32'd2);
    chk("t4_fb0",       32'(qf(0) - n), 32'd2);
    chk("t4_fb1",       32'(qf(1) - n), 32'd5);
    chk("t4_fb3",       32'(qf(3) - n), 32'd11);
    chk("t4_busy_idle", 32'(BUSY), 32'd0);

    // Reset while pacing with two characters queued
    clear_mon();
    strobe(CLS_DIGIT, 4'd1);
    strobe(CLS_DIGIT, 4'd2);
    strobe(CLS_DIGIT, 4'd3);
    tick();
    tick();
    chk("t5_busy_pre", 32'(BUSY), 32'd1);
    chk("t5_data_pre", 32'(bus.TX_DATA), 32'h31);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_tx_data",  32'(bus.TX_DATA), 32'h00);
    chk("t5_rst_tx_valid", 32'(bus.TX_VALID), 32'd0);
    chk("t5_rst_fb",       32'(FB), 32'd0);
    chk("t5_rst_busy",     32'(BUSY), 32'd0);
    chk("t5_rst_full",     32'(FULL), 32'd0);
    chk("t5_rst_overrun",  32'(OVERRUN), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    repeat (20) tick();
    chk("t5_fb_count", 32'(fb_cnt), 32'd0);
    chk("t5_busy",     32'(BUSY), 32'd0);
    chk("t5_nbytes",   32'(bytes_q.size()), 32'd1);

    // Sign, digit 0, digit 15, tab; each FB spaced by at least the pacing
    clear_mon();
    strobe(CLS_SIGN, 4'd1);
    strobe(CLS_DIGIT, 4'd0);
    strobe(CLS_DIGIT, 4'd15);
    strobe(CLS_TAB, 4'd0);
    wait_fb(4, 300, "t6_fb_timeout");
    chk("t6_nbytes", 32'(bytes_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("t6_byte", 32'(qb(i)), 32'(exp6[i]));
    for (int i = 1; i < 4; i++)
      chk("t6_fb_gap", 32'((qf(i) - qf(i - 1)) >= int'(CHAR_TICKS)), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
